// File: rtl/prog_loader_if.sv
// Host byte stream and i_mem write port of the program loader.
// Slave is the loader side, master is the host/memory side.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/prog_loader.sv
// Frame receiver that writes a checksummed program into i_mem
// and holds the CPU in reset until a verified frame has been loaded.
module prog_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            n_rst,
    prog_loader_if.slave    bus,
    output logic            cpu_n_rst,
    output logic            loading,
    output logic            done,
    output logic            error,
    output logic [ADDR_W:0] byte_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              cpu_n_rst_q, cpu_n_rst_d;
    logic              loading_q, loading_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic              in_frame;
    logic [8:0]        len_n;
    logic [ADDR_W:0]   cnt_inc;
    logic [7:0]        chk_sum;

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        tmo_d     = tmo_q;

        accept   = bus.in_valid & in_ready_q;
        in_frame = (state_q == S_LEN) || (state_q == S_DATA) ||
                   (state_q == S_CHK);
        len_n    = (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
        cnt_inc  = cnt_q + (ADDR_W+1)'(1);
        chk_sum  = sum_q + bus.in_data;

        if (accept) begin
            unique case (state_q)
                S_IDLE, S_RUN, S_ERR: begin
                    if (bus.in_data == 8'hA5) state_d = S_LEN;
                end
                S_LEN: begin
                    if (len_n > 9'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = len_n[ADDR_W:0];
                        cnt_d   = '0;
                        sum_d   = '0;
                        addr_d  = '0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = bus.in_data;
                    sum_d     = chk_sum;
                    addr_d    = addr_q + ADDR_W'(1);
                    cnt_d     = cnt_inc;
                    if (cnt_inc == len_q) state_d = S_CHK;
                end
                S_CHK: begin
                    state_d = (chk_sum == 8'h00) ? S_RUN : S_ERR;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // an accepted byte always beats the idle limit in the same cycle
        if (!in_frame || accept || TIMEOUT == 0) begin
            tmo_d = '0;
        end else if (32'(tmo_q) + 32'd1 >= 32'(TIMEOUT)) begin
            tmo_d   = '0;
            state_d = S_ERR;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        loading_d   = (state_d == S_LEN) || (state_d == S_DATA) ||
                      (state_d == S_CHK);
        done_d      = (state_d == S_RUN);
        cpu_n_rst_d = (state_d == S_RUN);
        error_d     = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            cpu_n_rst_q <= 1'b0;
            loading_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= 1'b1;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            cpu_n_rst_q <= cpu_n_rst_d;
            loading_q   <= loading_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign cpu_n_rst    = cpu_n_rst_q;
    assign loading      = loading_q;
    assign done         = done_q;
    assign error        = error_q;
    assign byte_count   = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: one 8-bit instance with a short
// idle limit and one 4-bit instance for the oversize-length case.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       sel4 = 1'b0;

    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(8)) bus ();
    prog_loader_if #(.ADDR_W(4)) bus4 ();

    assign bus.in_valid  = in_valid & ~sel4;
    assign bus.in_data   = in_data;
    assign bus4.in_valid = in_valid & sel4;
    assign bus4.in_data  = in_data;

    logic       cpu_n_rst, loading, done, error;
    logic [8:0] byte_count;
    logic       cpu_n_rst4, loading4, done4, error4;
    logic [4:0] byte_count4;

    prog_loader #(.ADDR_W(8), .TIMEOUT(8)) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus),
        .cpu_n_rst(cpu_n_rst), .loading(loading), .done(done),
        .error(error), .byte_count(byte_count)
    );

    prog_loader #(.ADDR_W(4), .TIMEOUT(0)) dut4 (
        .clk(clk), .n_rst(n_rst), .bus(bus4),
        .cpu_n_rst(cpu_n_rst4), .loading(loading4), .done(done4),
        .error(error4), .byte_count(byte_count4)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] pl[$];
    int         tests = 0;
    int         fails = 0;
    int         wr4 = 0;
    logic [7:0] last_addr = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // scoreboard side: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (bus.wr_en) begin
            last_addr <= bus.wr_addr;
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e.a));
                chk("wr_data", 32'(bus.wr_data), 32'(e.d));
            end
        end
        if (bus4.wr_en) wr4++;
    end

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] csum();
        logic [7:0] s = 8'h00;
        foreach (pl[i]) s = s + pl[i];
        return 8'h00 - s;
    endfunction

    // sync, length, payload (pushing expected writes), then check byte
    task automatic frame(input logic [7:0] c);
        send(8'hA5);
        send(8'(pl.size()));
        foreach (pl[i]) begin
            exp_q.push_back('{a: 8'(i), d: pl[i]});
            send(pl[i]);
        end
        send(c);
    endtask

    task automatic status(input string tag, input logic d,
                          input logic e, input logic l);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_error"}, 32'(error), 32'(e));
        chk({tag, "_loading"}, 32'(loading), 32'(l));
        chk({tag, "_cpu_n_rst"}, 32'(cpu_n_rst), 32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // reset values
        n_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_byte_count", 32'(byte_count), 32'd0);
        status("rst", 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("in_ready_up", 32'(bus.in_ready), 32'd1);

        // good three-byte frame
        pl = '{8'h11, 8'h22, 8'h33};
        frame(8'h9A);
        status("t1", 1'b1, 1'b0, 1'b0);
        chk("t1_byte_count", 32'(byte_count), 32'd3);

        // bad checksum, then a good one-byte frame
        pl = '{8'h10, 8'h20};
        frame(8'h00);
        status("t2_bad", 1'b0, 1'b1, 1'b0);
        pl = '{8'h7F};
        frame(8'h81);
        status("t2_good", 1'b1, 1'b0, 1'b0);
        chk("t2_byte_count", 32'(byte_count), 32'd1);

        // oversize length on the 16-byte instance
        sel4 = 1'b1;
        send(8'hA5);
        chk("t3_len_state", 32'(loading4), 32'd1);
        send(8'h11);
        chk("t3_error", 32'(error4), 32'd1);
        chk("t3_loading", 32'(loading4), 32'd0);
        chk("t3_cpu", 32'(cpu_n_rst4), 32'd0);
        send(8'h01);
        send(8'h02);
        idle(2);
        chk("t3_no_writes", 32'(wr4), 32'd0);
        chk("t3_still_error", 32'(error4), 32'd1);
        sel4 = 1'b0;

        // LEN=00 means 256 bytes
        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(8'(i * 7 + 3));
        frame(csum());
        status("t3_256", 1'b1, 1'b0, 1'b0);
        chk("t3_256_count", 32'(byte_count), 32'd256);
        chk("t3_256_last_addr", 32'(last_addr), 32'hFF);

        // 8 idle cycles inside a frame time out
        send(8'hA5);
        send(8'h02);
        exp_q.push_back('{a: 8'h00, d: 8'h10});
        send(8'h10);
        idle(7);
        chk("t4_pre_error", 32'(error), 32'd0);
        idle(1);
        status("t4_tmo", 1'b0, 1'b1, 1'b0);
        // a byte on the eighth cycle keeps the frame alive
        send(8'hA5);
        send(8'h02);
        exp_q.push_back('{a: 8'h00, d: 8'h10});
        send(8'h10);
        idle(7);
        exp_q.push_back('{a: 8'h01, d: 8'h20});
        send(8'h20);
        status("t4_edge", 1'b0, 1'b0, 1'b1);
        send(8'hD0);
        status("t4_done", 1'b1, 1'b0, 1'b0);

        // reset in the middle of a frame
        send(8'hA5);
        send(8'h04);
        exp_q.push_back('{a: 8'h00, d: 8'h01});
        send(8'h01);
        exp_q.push_back('{a: 8'h01, d: 8'h02});
        send(8'h02);
        n_rst = 1'b0;
        @(negedge clk);
        status("t5_rst", 1'b0, 1'b0, 1'b0);
        chk("t5_wr_en", 32'(bus.wr_en), 32'd0);
        chk("t5_count", 32'(byte_count), 32'd0);
        chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);
        send(8'h11);
        send(8'h22);
        status("t5_stray", 1'b0, 1'b0, 1'b0);
        pl = '{8'h5A, 8'h5B};
        frame(csum());
        status("t5_reload", 1'b1, 1'b0, 1'b0);
        chk("t5_byte_count", 32'(byte_count), 32'd2);

        // reload from RUN; a payload A5 is data
        send(8'hA5);
        status("t6_len", 1'b0, 1'b0, 1'b1);
        send(8'h03);
        exp_q.push_back('{a: 8'h00, d: 8'hA5});
        send(8'hA5);
        chk("t6_in_data", 32'(loading), 32'd1);
        exp_q.push_back('{a: 8'h01, d: 8'h01});
        send(8'h01);
        exp_q.push_back('{a: 8'h02, d: 8'h02});
        send(8'h02);
        send(8'h58);
        status("t6_done", 1'b1, 1'b0, 1'b0);
        chk("t6_byte_count", 32'(byte_count), 32'd3);

        idle(2);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
